// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : trap_ctrl_pkg
//  Brief   : Shared state encodings and sizing helper for the trap controller
//  Revision: 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

   // Trap sequencer states (3-bit encodings shared with the CSR side)
   typedef enum logic [2:0] {
      TRAP_ST_IDLE    = 3'd0,
      TRAP_ST_PENDING = 3'd1,
      TRAP_ST_SAVE    = 3'd2,
      TRAP_ST_JUMP    = 3'd3,
      TRAP_ST_MRET    = 3'd4
   } trap_state_e;

   localparam int XLEN = 32;

   // Width of a counter that must reach value (n-1); never narrower than 1 bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module  : sync_ff
//  Brief   : Reset-to-0 flop-chain synchronizer for a single async level
//  Revision: 1.0 - initial release
// ============================================================================
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the async input through STAGES flops; the last one is metastability-safe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : trap_ctrl
//  Brief   : External-interrupt trap entry and MRET sequencer driving the CSR
//            trap interface and the PC redirect
//  Revision: 1.0 - initial release
// ============================================================================
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq_i,
   input  logic        interrupt_enable_i,
   input  logic [31:0] tvec_i,
   input  logic [31:0] epc_i,
   input  logic        instr_retire_i,
   input  logic [31:0] next_pc_i,
   input  logic        mret_i,
   input  logic [31:0] fetch_pc_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic        pc_set_o,
   output logic [31:0] pc_target_o,
   output logic        save_epc_o,
   output logic [31:0] save_pc_o,
   output logic        mret_o,
   output logic        irq_ack_o
);

   localparam int                CNT_W    = cnt_width(DRAIN_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   trap_state_e      state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             stall_q,   stall_d;
   logic             flush_q,   flush_d;
   logic             pc_set_q,  pc_set_d;
   logic [31:0]      target_q,  target_d;
   logic             save_q,    save_d;
   logic [31:0]      save_pc_q, save_pc_d;
   logic             mret_q,    mret_d;
   logic             ack_q,     ack_d;
   logic             irq_s;
   logic             take;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_irq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (irq_i),
      .q_o   (irq_s)
   );

   assign take = irq_s & interrupt_enable_i;

   // Next state plus the output values that belong to that next state, so every
   // output flop asserts in the same cycle its state is entered
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_d   = 1'b0;
      flush_d   = 1'b0;
      pc_set_d  = 1'b0;
      target_d  = '0;
      save_d    = 1'b0;
      save_pc_d = '0;
      mret_d    = 1'b0;
      ack_d     = 1'b0;
      case (state_q)
         TRAP_ST_IDLE: begin
            cnt_d = '0;
            // MRET wins over a newly pending interrupt in the same cycle
            if (mret_i && instr_retire_i) begin
               state_d  = TRAP_ST_MRET;
               flush_d  = 1'b1;
               pc_set_d = 1'b1;
               target_d = epc_i;
               mret_d   = 1'b1;
            end else if (take) begin
               state_d = TRAP_ST_PENDING;
               stall_d = 1'b1;
            end
         end
         TRAP_ST_PENDING: begin
            if (!take) begin
               state_d = TRAP_ST_IDLE;
               cnt_d   = '0;
            end else if (instr_retire_i) begin
               // Boundary reached: resume point is the instruction after the
               // retiring one; an MRET retiring here is deliberately dropped
               state_d   = TRAP_ST_SAVE;
               stall_d   = 1'b1;
               save_d    = 1'b1;
               save_pc_d = next_pc_i;
            end else if (cnt_q == CNT_LAST) begin
               // Pipeline never drained; trap at whatever is being fetched
               state_d   = TRAP_ST_SAVE;
               stall_d   = 1'b1;
               save_d    = 1'b1;
               save_pc_d = fetch_pc_i;
            end else begin
               stall_d = 1'b1;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         TRAP_ST_SAVE: begin
            // Committed: irq/MIE are no longer consulted
            state_d  = TRAP_ST_JUMP;
            stall_d  = 1'b1;
            flush_d  = 1'b1;
            pc_set_d = 1'b1;
            target_d = tvec_i;
            ack_d    = 1'b1;
         end
         TRAP_ST_JUMP: state_d = TRAP_ST_IDLE;
         TRAP_ST_MRET: state_d = TRAP_ST_IDLE;
         default:      state_d = TRAP_ST_IDLE;
      endcase
   end

   // State, counter and registered outputs; async reset aborts any sequence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= TRAP_ST_IDLE;
         cnt_q     <= '0;
         stall_q   <= 1'b0;
         flush_q   <= 1'b0;
         pc_set_q  <= 1'b0;
         target_q  <= '0;
         save_q    <= 1'b0;
         save_pc_q <= '0;
         mret_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
         pc_set_q  <= pc_set_d;
         target_q  <= target_d;
         save_q    <= save_d;
         save_pc_q <= save_pc_d;
         mret_q    <= mret_d;
         ack_q     <= ack_d;
      end
   end

   assign stall_o     = stall_q;
   assign flush_o     = flush_q;
   assign pc_set_o    = pc_set_q;
   assign pc_target_o = target_q;
   assign save_epc_o  = save_q;
   assign save_pc_o   = save_pc_q;
   assign mret_o      = mret_q;
   assign irq_ack_o   = ack_q;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_trap_ctrl
//  Brief   : Directed self-checking bench for trap_ctrl
//  Revision: 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq_i;
   logic        interrupt_enable_i;
   logic [31:0] tvec_i;
   logic [31:0] epc_i;
   logic        instr_retire_i;
   logic [31:0] next_pc_i;
   logic        mret_i;
   logic [31:0] fetch_pc_i;
   logic        stall_o;
   logic        flush_o;
   logic        pc_set_o;
   logic [31:0] pc_target_o;
   logic        save_epc_o;
   logic [31:0] save_pc_o;
   logic        mret_o;
   logic        irq_ack_o;

   int total = 0;
   int bad   = 0;

   trap_ctrl #(
      .SYNC_STAGES   (2),
      .DRAIN_TIMEOUT (16)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .irq_i              (irq_i),
      .interrupt_enable_i (interrupt_enable_i),
      .tvec_i             (tvec_i),
      .epc_i              (epc_i),
      .instr_retire_i     (instr_retire_i),
      .next_pc_i          (next_pc_i),
      .mret_i             (mret_i),
      .fetch_pc_i         (fetch_pc_i),
      .stall_o            (stall_o),
      .flush_o            (flush_o),
      .pc_set_o           (pc_set_o),
      .pc_target_o        (pc_target_o),
      .save_epc_o         (save_epc_o),
      .save_pc_o          (save_pc_o),
      .mret_o             (mret_o),
      .irq_ack_o          (irq_ack_o)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drop the interrupt and let the synchronizer flush back to 0
   task automatic quiesce();
      irq_i = 1'b0; interrupt_enable_i = 1'b0;
      instr_retire_i = 1'b0; mret_i = 1'b0;
      tick(4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      irq_i = 1'b0; interrupt_enable_i = 1'b0; instr_retire_i = 1'b0; mret_i = 1'b0;
      tvec_i = 32'h80; epc_i = 32'h0; next_pc_i = 32'h0; fetch_pc_i = 32'h0;
      tick(3);
      total++;
      if ({stall_o, flush_o, pc_set_o, save_epc_o, mret_o, irq_ack_o} !== 6'b0 ||
          pc_target_o !== 32'h0 || save_pc_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: strobes=%b target=%h save_pc=%h required all 0",
                  {stall_o, flush_o, pc_set_o, save_epc_o, mret_o, irq_ack_o}, pc_target_o, save_pc_o);
      end
      rst_n = 1'b1;
      tick(2);
      total++;
      if (stall_o !== 1'b0) begin
         bad++; $display("FAIL reset_idle_stall: got %b required 0", stall_o);
      end
   endtask

   task automatic test_trap_retire();
      irq_i = 1'b1; interrupt_enable_i = 1'b1;
      tick(3);
      total++;
      if (stall_o !== 1'b1) begin
         bad++; $display("FAIL t1_pending_stall: got %b required 1", stall_o);
      end
      instr_retire_i = 1'b1; next_pc_i = 32'h104;
      tick(1);
      instr_retire_i = 1'b0;
      total++;
      if (save_epc_o !== 1'b1 || save_pc_o !== 32'h104 || stall_o !== 1'b1 || pc_set_o !== 1'b0) begin
         bad++; $display("FAIL t1_save: save=%b pc=%h stall=%b pc_set=%b required 1 00000104 1 0",
                         save_epc_o, save_pc_o, stall_o, pc_set_o);
      end
      // CSR clears MIE on the save strobe
      interrupt_enable_i = 1'b0;
      tick(1);
      total++;
      if (pc_set_o !== 1'b1 || pc_target_o !== 32'h80 || flush_o !== 1'b1 ||
          irq_ack_o !== 1'b1 || save_epc_o !== 1'b0 || stall_o !== 1'b1) begin
         bad++; $display("FAIL t1_jump: pc_set=%b target=%h flush=%b ack=%b save=%b stall=%b required 1 00000080 1 1 0 1",
                         pc_set_o, pc_target_o, flush_o, irq_ack_o, save_epc_o, stall_o);
      end
      tick(1);
      total++;
      if (pc_set_o !== 1'b0 || stall_o !== 1'b0 || irq_ack_o !== 1'b0) begin
         bad++; $display("FAIL t1_back_idle: pc_set=%b stall=%b ack=%b required 0 0 0",
                         pc_set_o, stall_o, irq_ack_o);
      end
      quiesce();
   endtask

   task automatic test_mie_gate();
      int seen = 0;
      irq_i = 1'b1; interrupt_enable_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (stall_o !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL t2_masked_stall: stall seen %0d cycles required 0", seen);
      end
      interrupt_enable_i = 1'b1;
      tick(1);
      total++;
      if (stall_o !== 1'b1) begin
         bad++; $display("FAIL t2_unmasked_pending: stall=%b required 1", stall_o);
      end
      quiesce();
   endtask

   task automatic test_timeout();
      int early = 0;
      fetch_pc_i = 32'h200;
      irq_i = 1'b1; interrupt_enable_i = 1'b1;
      tick(3);
      for (int i = 1; i < 16; i++) begin
         tick(1);
         if (save_epc_o !== 1'b0 || stall_o !== 1'b1) early++;
      end
      total++;
      if (early != 0) begin
         bad++; $display("FAIL t3_early_save: bad cycles %0d required 0", early);
      end
      tick(1);
      total++;
      if (save_epc_o !== 1'b1 || save_pc_o !== 32'h200) begin
         bad++; $display("FAIL t3_timeout_save: save=%b pc=%h required 1 00000200", save_epc_o, save_pc_o);
      end
      interrupt_enable_i = 1'b0;
      tick(1);
      total++;
      if (pc_set_o !== 1'b1 || pc_target_o !== 32'h80) begin
         bad++; $display("FAIL t3_jump: pc_set=%b target=%h required 1 00000080", pc_set_o, pc_target_o);
      end
      quiesce();
   endtask

   task automatic test_mret_priority();
      irq_i = 1'b1; interrupt_enable_i = 1'b0;
      tick(3);
      interrupt_enable_i = 1'b1; mret_i = 1'b1; instr_retire_i = 1'b1; epc_i = 32'h104;
      tick(1);
      mret_i = 1'b0; instr_retire_i = 1'b0;
      total++;
      if (pc_set_o !== 1'b1 || pc_target_o !== 32'h104 || mret_o !== 1'b1 ||
          flush_o !== 1'b1 || stall_o !== 1'b0 || irq_ack_o !== 1'b0) begin
         bad++; $display("FAIL t4_mret: pc_set=%b target=%h mret=%b flush=%b stall=%b ack=%b required 1 00000104 1 1 0 0",
                         pc_set_o, pc_target_o, mret_o, flush_o, stall_o, irq_ack_o);
      end
      tick(1);
      total++;
      if (stall_o !== 1'b0 || pc_set_o !== 1'b0 || mret_o !== 1'b0) begin
         bad++; $display("FAIL t4_idle_after_mret: stall=%b pc_set=%b mret=%b required 0 0 0",
                         stall_o, pc_set_o, mret_o);
      end
      tick(1);
      total++;
      if (stall_o !== 1'b1) begin
         bad++; $display("FAIL t4_trap_follows: stall=%b required 1", stall_o);
      end
      quiesce();
   endtask

   task automatic test_irq_drop();
      int saves = 0;
      irq_i = 1'b1; interrupt_enable_i = 1'b1;
      tick(3);
      irq_i = 1'b0;
      tick(2);
      if (save_epc_o !== 1'b0) saves++;
      total++;
      if (stall_o !== 1'b1) begin
         bad++; $display("FAIL t5_still_pending: stall=%b required 1", stall_o);
      end
      tick(1);
      if (save_epc_o !== 1'b0) saves++;
      total++;
      if (stall_o !== 1'b0) begin
         bad++; $display("FAIL t5_stall_released: stall=%b required 0", stall_o);
      end
      tick(3);
      if (save_epc_o !== 1'b0 || pc_set_o !== 1'b0) saves++;
      total++;
      if (saves != 0) begin
         bad++; $display("FAIL t5_no_save: save/redirect seen %0d times required 0", saves);
      end
      quiesce();
   endtask

   task automatic test_reset_in_save();
      int redirects = 0;
      irq_i = 1'b1; interrupt_enable_i = 1'b1;
      tick(3);
      instr_retire_i = 1'b1; next_pc_i = 32'h300;
      tick(1);
      instr_retire_i = 1'b0;
      total++;
      if (save_epc_o !== 1'b1 || save_pc_o !== 32'h300) begin
         bad++; $display("FAIL t6_in_save: save=%b pc=%h required 1 00000300", save_epc_o, save_pc_o);
      end
      rst_n = 1'b0;
      irq_i = 1'b0; interrupt_enable_i = 1'b0;
      #1;
      total++;
      if ({stall_o, flush_o, pc_set_o, save_epc_o, mret_o, irq_ack_o} !== 6'b0 ||
          pc_target_o !== 32'h0 || save_pc_o !== 32'h0) begin
         bad++; $display("FAIL t6_async_clear: strobes=%b target=%h save_pc=%h required all 0",
                         {stall_o, flush_o, pc_set_o, save_epc_o, mret_o, irq_ack_o}, pc_target_o, save_pc_o);
      end
      tick(2);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (pc_set_o !== 1'b0 || stall_o !== 1'b0 || irq_ack_o !== 1'b0) redirects++;
      end
      total++;
      if (redirects != 0) begin
         bad++; $display("FAIL t6_no_resume: activity seen %0d cycles required 0", redirects);
      end
   endtask

   initial begin
      test_reset();
      test_trap_retire();
      test_mie_gate();
      test_timeout();
      test_mret_priority();
      test_irq_drop();
      test_reset_in_save();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a wait is ever mis-sequenced
   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached required finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_trap_ctrl
`default_nettype wire
